// File: rtl/button_reader.sv
`default_nettype none
// ============================================================================
//  Module   : button_reader
//  Purpose  : Synchronises and debounces up to N_BTN raw push-button pins.
//             Per channel it produces a clean pressed level, one-cycle
//             press/release strobes and a press-toggled state bit.
//  Options  : LONG_PRESS_EN - when defined, adds a per-channel hold counter
//             and a one-shot LONG_PULSE after LONG_TICKS sample ticks of
//             continuous hold; otherwise LONG_PULSE is constant 0.
//  Revision : 1.0 - initial release
// ============================================================================
module button_reader #(
    parameter int N_BTN        = 4,
    parameter int SAMPLE_DIV   = 3300,
    parameter int DEBOUNCE_CNT = 8,
    parameter int ACTIVE_LOW   = 1,
    parameter int LONG_TICKS   = 1000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_BTN-1:0] BTN,
    input  logic [N_BTN-1:0] TOGGLE_CLR,
    output logic [N_BTN-1:0] LEVEL,
    output logic [N_BTN-1:0] PRESS_PULSE,
    output logic [N_BTN-1:0] RELEASE_PULSE,
    output logic [N_BTN-1:0] TOGGLE,
    output logic [N_BTN-1:0] LONG_PULSE
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [PW-1:0]    PRESC_LAST = PW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0]    CNT_LAST   = CW'(DEBOUNCE_CNT - 1);
    // Pin level of an unpressed button; also the XOR mask that normalises
    // synchronised pins to 1 = pressed.
    localparam logic [N_BTN-1:0] IDLE_PIN   = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : {N_BTN{1'b0}};

    localparam logic [1:0] ST_RELEASED     = 2'd0;
    localparam logic [1:0] ST_PRESS_PEND   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_PEND = 2'd3;

`ifdef LONG_PRESS_EN
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
`endif

    logic [N_BTN-1:0] sync_1;
    logic [N_BTN-1:0] sync_2;
    logic [N_BTN-1:0] pressed_now;
    logic [PW-1:0]    presc;
    logic             tick;

    // Two-flop synchroniser; resets to the idle pin level so no false press
    // is seen while the chain refills after reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync_1 <= IDLE_PIN;
            sync_2 <= IDLE_PIN;
        end else begin
            sync_1 <= BTN;
            sync_2 <= sync_1;
        end
    end

    assign pressed_now = sync_2 ^ IDLE_PIN;

    // Shared sample prescaler: tick marks the last count of each period.
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge CLK) begin
        if (RESET || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        logic [1:0]    state;
        logic [CW-1:0] cnt;
        logic          level_bit;
        logic          press_strobe;
        logic          release_strobe;
        logic          toggle_bit;

        // Debounce FSM: advances on sample ticks only; strobes are registered
        // so they appear the cycle after the deciding tick.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                state          <= ST_RELEASED;
                cnt            <= '0;
                level_bit      <= 1'b0;
                press_strobe   <= 1'b0;
                release_strobe <= 1'b0;
            end else begin
                press_strobe   <= 1'b0;
                release_strobe <= 1'b0;
                if (tick) begin
                    case (state)
                        ST_RELEASED: begin
                            if (pressed_now[i]) begin
                                state <= ST_PRESS_PEND;
                                cnt   <= CW'(1);
                            end
                        end
                        ST_PRESS_PEND: begin
                            if (!pressed_now[i]) begin
                                state <= ST_RELEASED;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state        <= ST_PRESSED;
                                cnt          <= '0;
                                level_bit    <= 1'b1;
                                press_strobe <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        ST_PRESSED: begin
                            if (!pressed_now[i]) begin
                                state <= ST_RELEASE_PEND;
                                cnt   <= CW'(1);
                            end
                        end
                        default: begin
                            if (pressed_now[i]) begin
                                state <= ST_PRESSED;
                                cnt   <= '0;
                            end else if (cnt == CNT_LAST) begin
                                state          <= ST_RELEASED;
                                cnt            <= '0;
                                level_bit      <= 1'b0;
                                release_strobe <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    endcase
                end
            end
        end

        // Toggle flips on the press-strobe cycle; a clear in that same cycle
        // still leaves the bit set because the press takes priority.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                toggle_bit <= 1'b0;
            end else if (press_strobe) begin
                toggle_bit <= TOGGLE_CLR[i] | ~toggle_bit;
            end else if (TOGGLE_CLR[i]) begin
                toggle_bit <= 1'b0;
            end
        end

        assign LEVEL[i]         = level_bit;
        assign PRESS_PULSE[i]   = press_strobe;
        assign RELEASE_PULSE[i] = release_strobe;
        assign TOGGLE[i]        = toggle_bit;

`ifdef LONG_PRESS_EN
        logic [HW-1:0] hold;
        logic          long_strobe;
        logic          release_done;

        assign release_done = (state == ST_RELEASE_PEND) && !pressed_now[i] && (cnt == CNT_LAST);

        // Hold counter: counts ticks while held, saturates so the long strobe
        // fires once, and is cleared when the channel returns to RELEASED.
        always_ff @(posedge CLK) begin
            if (RESET) begin
                hold        <= '0;
                long_strobe <= 1'b0;
            end else begin
                long_strobe <= 1'b0;
                if (tick) begin
                    if ((state == ST_PRESSED) || (state == ST_RELEASE_PEND)) begin
                        if (release_done) begin
                            hold <= '0;
                        end else if (hold != HOLD_MAX) begin
                            hold <= hold + 1'b1;
                            if (hold == HOLD_LAST) begin
                                long_strobe <= 1'b1;
                            end
                        end
                    end else begin
                        hold <= '0;
                    end
                end
            end
        end

        assign LONG_PULSE[i] = long_strobe;
`endif
    end

`ifndef LONG_PRESS_EN
    // LONG_TICKS is a non-negative count, so this is constant 0.
    assign LONG_PULSE = {N_BTN{(LONG_TICKS < 0)}};
`endif

endmodule
`default_nettype wire
